led_breathe: RTL and testbench



---
 rtl/led_breathe_if.sv | 11 +
 rtl/led_breathe.sv | 77 +++++++
 tb/tb_led_breathe.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/led_breathe_if.sv
// led_breathe_if: tick/enable inputs and LED/envelope status outputs of the breathing LED driver.
interface led_breathe_if #(parameter int PWM_BITS = 8);
  logic                i_tick;
  logic                i_enable;
  logic                o_led;
  logic [PWM_BITS-1:0] o_duty;
  logic [1:0]          o_phase;
  logic                o_cycle_done;
  modport master (output i_tick, i_enable, input o_led, o_duty, o_phase, o_cycle_done);
  modport slave  (input i_tick, i_enable, output o_led, o_duty, o_phase, o_cycle_done);
endinterface

// File: rtl/led_breathe.sv
// led_breathe: PWM LED driver whose duty follows a tick-stepped ramp-up/hold/ramp-down/hold envelope.
module led_breathe #(
  parameter int PWM_BITS   = 8,
  parameter int STEP       = 1,
  parameter int HOLD_TICKS = 16
) (
  input logic           i_clk,
  input logic           i_rst,
  led_breathe_if.slave  bus
);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [PWM_BITS-1:0] MAX_D     = '1;
  localparam logic [PWM_BITS-1:0] STEP_D    = PWM_BITS'(STEP);
  localparam logic [PWM_BITS:0]   STEP_X    = (PWM_BITS + 1)'(STEP);
  localparam logic [PWM_BITS:0]   UP_LIM    = (PWM_BITS + 1)'((2 ** PWM_BITS) - 1 - STEP);
  localparam logic [HW-1:0]       HOLD_LAST = HW'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {RAMP_UP, HOLD_HIGH, RAMP_DOWN, HOLD_LOW} phase_t;

  logic [PWM_BITS-1:0] r_pwm_ctr;
  logic [PWM_BITS-1:0] r_duty;
  logic [PWM_BITS-1:0] r_duty_active;
  logic [HW-1:0]       r_hold_ctr;
  phase_t              r_phase;
  logic                r_led;
  logic                r_cycle_done;
  logic [PWM_BITS:0]   w_duty_x;

  assign w_duty_x = {1'b0, r_duty};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pwm_ctr     <= '0;
      r_duty        <= '0;
      r_duty_active <= '0;
      r_hold_ctr    <= '0;
      r_phase       <= RAMP_UP;
      r_led         <= 1'b0;
      r_cycle_done  <= 1'b0;
    end else begin
      r_pwm_ctr    <= r_pwm_ctr + 1'b1;
      // shadow the duty only at period end so a PWM period never changes mid-way
      if (r_pwm_ctr == MAX_D) r_duty_active <= r_duty;
      r_led        <= bus.i_enable && (r_pwm_ctr < r_duty_active);
      r_cycle_done <= 1'b0;
      if (bus.i_tick && bus.i_enable) begin
        case (r_phase)
          RAMP_UP:
            if (w_duty_x >= UP_LIM) begin
              r_duty     <= MAX_D;
              r_hold_ctr <= '0;
              r_phase    <= HOLD_HIGH;
            end else r_duty <= r_duty + STEP_D;
          HOLD_HIGH:
            if (r_hold_ctr == HOLD_LAST) r_phase <= RAMP_DOWN;
            else r_hold_ctr <= r_hold_ctr + 1'b1;
          RAMP_DOWN:
            if (w_duty_x <= STEP_X) begin
              r_duty     <= '0;
              r_hold_ctr <= '0;
              r_phase    <= HOLD_LOW;
            end else r_duty <= r_duty - STEP_D;
          HOLD_LOW:
            if (r_hold_ctr == HOLD_LAST) begin
              r_phase      <= RAMP_UP;
              r_cycle_done <= 1'b1;
            end else r_hold_ctr <= r_hold_ctr + 1'b1;
        endcase
      end
    end
  end

  assign bus.o_led        = r_led;
  assign bus.o_duty       = r_duty;
  assign bus.o_phase      = r_phase;
  assign bus.o_cycle_done = r_cycle_done;
endmodule

// File: tb/tb_led_breathe.sv
// tb_led_breathe: two DUTs (STEP 1 and 3, PWM_BITS 4, HOLD_TICKS 2) sharing stimulus, checked against an envelope model.
module tb_led_breathe;
  localparam int B = 4, H = 2, MAXV = 15;
  logic clk = 1'b0, rst = 1'b1, tick = 1'b0, en = 1'b1;
  int tests = 0, fails = 0;

  led_breathe_if #(.PWM_BITS(B)) ifa ();
  led_breathe_if #(.PWM_BITS(B)) ifb ();
  assign ifa.i_tick = tick;
  assign ifa.i_enable = en;
  assign ifb.i_tick = tick;
  assign ifb.i_enable = en;

  led_breathe #(.PWM_BITS(B), .STEP(1), .HOLD_TICKS(H)) dut_a (.i_clk(clk), .i_rst(rst), .bus(ifa));
  led_breathe #(.PWM_BITS(B), .STEP(3), .HOLD_TICKS(H)) dut_b (.i_clk(clk), .i_rst(rst), .bus(ifb));

  always #5 clk = ~clk;

  // Envelope position is a pure function of enabled ticks since reset.
  function automatic int ramp_len(int step);
    return (MAXV + step - 1) / step;
  endfunction
  function automatic int env_period(int step);
    return 2 * ramp_len(step) + 2 * H;
  endfunction
  function automatic int exp_phase(int n, int step);
    int u = ramp_len(step), m = n % env_period(step);
    return m < u ? 0 : m < u + H ? 1 : m < 2 * u + H ? 2 : 3;
  endfunction
  function automatic int exp_duty(int n, int step);
    int u = ramp_len(step), m = n % env_period(step);
    return m < u ? m * step : m < u + H ? MAXV : m < 2 * u + H ? MAXV - (m - u - H) * step : 0;
  endfunction

  int steps[2] = '{1, 3};
  int m_n[2], m_dact[2], m_led[2], m_done[2], m_pwm;

  always @(posedge clk) begin
    if (rst) m_pwm <= 0;
    else m_pwm <= (m_pwm + 1) % (MAXV + 1);
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_n[i] <= 0; m_dact[i] <= 0; m_led[i] <= 0; m_done[i] <= 0;
      end else begin
        if (m_pwm == MAXV) m_dact[i] <= exp_duty(m_n[i], steps[i]);
        m_led[i]  <= (en && m_pwm < m_dact[i]) ? 1 : 0;
        m_n[i]    <= m_n[i] + ((tick && en) ? 1 : 0);
        m_done[i] <= (tick && en && ((m_n[i] + 1) % env_period(steps[i]) == 0)) ? 1 : 0;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    check("a_led", int'(ifa.o_led), m_led[0]);
    check("a_duty", int'(ifa.o_duty), exp_duty(m_n[0], 1));
    check("a_phase", int'(ifa.o_phase), exp_phase(m_n[0], 1));
    check("a_done", int'(ifa.o_cycle_done), m_done[0]);
    check("b_led", int'(ifb.o_led), m_led[1]);
    check("b_duty", int'(ifb.o_duty), exp_duty(m_n[1], 3));
    check("b_phase", int'(ifb.o_phase), exp_phase(m_n[1], 3));
    check("b_done", int'(ifb.o_cycle_done), m_done[1]);
  end

  task automatic ticks(input int k, input int gap);
    for (int i = 0; i < k; i++) begin
      @(negedge clk) tick = 1'b1;
      @(negedge clk) tick = 1'b0;
      for (int j = 1; j < gap; j++) @(negedge clk);
    end
  endtask

  initial begin
    int hi;
    repeat (3) @(negedge clk);
    check("rst_led", int'(ifa.o_led), 0);
    check("rst_duty", int'(ifa.o_duty), 0);
    check("rst_phase", int'(ifa.o_phase), 0);
    check("rst_done", int'(ifa.o_cycle_done), 0);
    rst = 1'b0;
    ticks(5, 1);
    check("lit_a_duty5", int'(ifa.o_duty), 5);
    check("lit_b_duty15", int'(ifb.o_duty), 15);
    check("lit_b_hold_high", int'(ifb.o_phase), 1);
    repeat (48) @(negedge clk);
    hi = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      hi += int'(ifa.o_led);
    end
    check("lit_pwm_high_cnt", hi, 5);
    ticks(2, 20);
    check("lit_a_duty7", int'(ifa.o_duty), 7);
    check("lit_b_ramp_down", int'(ifb.o_phase), 2);
    en = 1'b0;
    @(negedge clk);
    check("lit_gate_led", int'(ifa.o_led), 0);
    ticks(10, 1);
    check("lit_gate_duty", int'(ifa.o_duty), 7);
    check("lit_gate_phase", int'(ifa.o_phase), 0);
    en = 1'b1;
    ticks(1, 1);
    check("lit_reen_duty8", int'(ifa.o_duty), 8);
    check("lit_b_duty12", int'(ifb.o_duty), 12);
    @(negedge clk) tick = 1'b1;
    repeat (7) @(negedge clk);
    tick = 1'b0;
    check("lit_b_burst_duty", int'(ifb.o_duty), 3);
    check("lit_a_hold_high", int'(ifa.o_phase), 1);
    check("lit_a_duty15", int'(ifa.o_duty), 15);
    ticks(2, 20);
    check("lit_a_ramp_down", int'(ifa.o_phase), 2);
    ticks(15, 20);
    check("lit_a_hold_low", int'(ifa.o_phase), 3);
    check("lit_a_duty0", int'(ifa.o_duty), 0);
    ticks(1, 20);
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    check("lit_a_cycle_done", int'(ifa.o_cycle_done), 1);
    check("lit_a_wrap_phase", int'(ifa.o_phase), 0);
    @(negedge clk);
    check("lit_a_done_clear", int'(ifa.o_cycle_done), 0);
    ticks(16, 3);
    check("lit_a_mid_hold", int'(ifa.o_phase), 1);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check("lit_mrst_phase", int'(ifa.o_phase), 0);
    check("lit_mrst_duty", int'(ifa.o_duty), 0);
    check("lit_mrst_led", int'(ifa.o_led), 0);
    ticks(1, 1);
    check("lit_mrst_a_step", int'(ifa.o_duty), 1);
    check("lit_mrst_b_step", int'(ifb.o_duty), 3);
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
